// File: rtl/aes_sbox_sched_pkg.sv
// rtl/aes_sbox_sched_pkg.sv - shared types and constants for the masked S-box scheduler
package aes_sbox_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_KS = 2'd1,
        ISSUE_ST = 2'd2
    } state_e;

    localparam logic SRC_ST = 1'b0;
    localparam logic SRC_KS = 1'b1;

    typedef struct packed {
        logic       valid;
        logic       src;
        logic [3:0] idx;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, src: SRC_ST, idx: 4'd0};

endpackage

// File: rtl/aes_sbox_tag_pipe.sv
// rtl/aes_sbox_tag_pipe.sv - tag shift register running in lockstep with the pipelined S-box
module aes_sbox_tag_pipe
    import aes_sbox_sched_pkg::*;
#(
    parameter int SBOX_LAT = 4
) (
    input  logic ClkxCI,
    input  logic RstxBI,
    input  tag_t TagInxDI,
    output tag_t TagOutxDO
);

    tag_t [SBOX_LAT-1:0] pipe_q;
    tag_t [SBOX_LAT-1:0] pipe_d;

    always_comb begin
        pipe_d[0] = TagInxDI;
        for (int i = 1; i < SBOX_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            for (int i = 0; i < SBOX_LAT; i++) begin
                pipe_q[i] <= TAG_NONE;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign TagOutxDO = pipe_q[SBOX_LAT-1];

endmodule

// File: rtl/aes_sbox_sched.sv
// rtl/aes_sbox_sched.sv - shares one pipelined masked S-box between the round datapath and key schedule
module aes_sbox_sched
    import aes_sbox_sched_pkg::*;
#(
    parameter int SHARES   = 2,
    parameter int SBOX_LAT = 4,
    parameter int NST      = 16,
    parameter int NKS      = 4
) (
    input  logic                     ClkxCI,
    input  logic                     RstxBI,
    input  logic                     StReqxSI,
    input  logic [8*SHARES*NST-1:0]  StDataxDI,
    input  logic                     KsReqxSI,
    input  logic [8*SHARES*NKS-1:0]  KsDataxDI,
    input  logic                     RandValidxSI,
    output logic                     RandReadyxSO,
    output logic [8*SHARES-1:0]      SboxInxDO,
    input  logic [8*SHARES-1:0]      SboxOutxDI,
    output logic [8*SHARES-1:0]      ResxDO,
    output logic [3:0]               ResIdxxDO,
    output logic                     ResStValxSO,
    output logic                     ResKsValxSO,
    output logic                     StDonexSO,
    output logic                     KsDonexSO
);

    localparam int         BW      = 8 * SHARES;
    localparam logic [3:0] ST_LAST = 4'(NST - 1);
    localparam logic [3:0] KS_LAST = 4'(NKS - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            st_busy_q, st_busy_d;
    logic            ks_busy_q, ks_busy_d;
    logic [BW-1:0]   res_q, res_d;
    logic [3:0]      res_idx_q, res_idx_d;
    logic            res_st_val_q, res_st_val_d;
    logic            res_ks_val_q, res_ks_val_d;
    logic            st_done_q, st_done_d;
    logic            ks_done_q, ks_done_d;

    logic            issue;
    logic            last_issue;
    logic            st_grant;
    logic            ks_grant;
    logic [BW-1:0]   st_byte;
    logic [BW-1:0]   ks_byte;
    tag_t            tag_in;
    tag_t            tag_out;

    always_comb begin
        st_byte = '0;
        ks_byte = '0;
        for (int i = 0; i < NST; i++) begin
            if (cnt_q == 4'(i)) st_byte = StDataxDI[BW*i +: BW];
        end
        for (int i = 0; i < NKS; i++) begin
            if (cnt_q == 4'(i)) ks_byte = KsDataxDI[BW*i +: BW];
        end
    end

    // a requester stays blocked from grant until the cycle after its done pulse
    assign ks_grant = KsReqxSI && !ks_busy_q;
    assign st_grant = StReqxSI && !st_busy_q;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ks_grant)      state_d = ISSUE_KS;
                else if (st_grant) state_d = ISSUE_ST;
            end
            ISSUE_KS: begin
                if (last_issue) state_d = st_grant ? ISSUE_ST : IDLE;
            end
            ISSUE_ST: begin
                if (last_issue) state_d = ks_grant ? ISSUE_KS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue      = (state_q != IDLE) && RandValidxSI;
        last_issue = issue && (cnt_q == ((state_q == ISSUE_KS) ? KS_LAST : ST_LAST));
        SboxInxDO  = '0;
        tag_in     = TAG_NONE;
        if (issue) begin
            SboxInxDO = (state_q == ISSUE_KS) ? ks_byte : st_byte;
            tag_in    = '{valid: 1'b1,
                          src:   (state_q == ISSUE_KS) ? SRC_KS : SRC_ST,
                          idx:   cnt_q};
        end
    end

    assign RandReadyxSO = issue;

    always_comb begin
        cnt_d = cnt_q;
        if (last_issue) cnt_d = '0;
        else if (issue) cnt_d = cnt_q + 4'd1;

        st_busy_d = st_busy_q;
        ks_busy_d = ks_busy_q;
        if (st_done_q) st_busy_d = 1'b0;
        if (ks_done_q) ks_busy_d = 1'b0;
        if (last_issue && state_q == ISSUE_ST) st_busy_d = 1'b1;
        if (last_issue && state_q == ISSUE_KS) ks_busy_d = 1'b1;
    end

    aes_sbox_tag_pipe #(
        .SBOX_LAT (SBOX_LAT)
    ) u_tag_pipe (
        .ClkxCI    (ClkxCI),
        .RstxBI    (RstxBI),
        .TagInxDI  (tag_in),
        .TagOutxDO (tag_out)
    );

    always_comb begin
        res_d        = SboxOutxDI;
        res_idx_d    = tag_out.valid ? tag_out.idx : 4'd0;
        res_st_val_d = tag_out.valid && (tag_out.src == SRC_ST);
        res_ks_val_d = tag_out.valid && (tag_out.src == SRC_KS);
        st_done_d    = res_st_val_d && (tag_out.idx == ST_LAST);
        ks_done_d    = res_ks_val_d && (tag_out.idx == KS_LAST);
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            cnt_q        <= '0;
            st_busy_q    <= 1'b0;
            ks_busy_q    <= 1'b0;
            res_q        <= '0;
            res_idx_q    <= '0;
            res_st_val_q <= 1'b0;
            res_ks_val_q <= 1'b0;
            st_done_q    <= 1'b0;
            ks_done_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            st_busy_q    <= st_busy_d;
            ks_busy_q    <= ks_busy_d;
            res_q        <= res_d;
            res_idx_q    <= res_idx_d;
            res_st_val_q <= res_st_val_d;
            res_ks_val_q <= res_ks_val_d;
            st_done_q    <= st_done_d;
            ks_done_q    <= ks_done_d;
        end
    end

    assign ResxDO      = res_q;
    assign ResIdxxDO   = res_idx_q;
    assign ResStValxSO = res_st_val_q;
    assign ResKsValxSO = res_ks_val_q;
    assign StDonexSO   = st_done_q;
    assign KsDonexSO   = ks_done_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// tb/tb_aes_sbox_sched.sv - bench for aes_sbox_sched with a behavioural masked S-box and scheduler model
module tb_aes_sbox_sched;

    localparam int SHARES   = 2;
    localparam int SBOX_LAT = 4;
    localparam int NST      = 16;
    localparam int NKS      = 4;
    localparam int BW       = 8 * SHARES;
    localparam int LAT      = SBOX_LAT + 1;
    localparam int NB_SOAK  = 500;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 st_req = 1'b0;
    logic                 ks_req = 1'b0;
    logic                 rand_valid = 1'b0;
    logic [BW*NST-1:0]    st_data = '0;
    logic [BW*NKS-1:0]    ks_data = '0;
    logic                 rand_ready;
    logic [BW-1:0]        sbox_in;
    logic [BW-1:0]        sbox_out;
    logic [BW-1:0]        res;
    logic [3:0]           res_idx;
    logic                 res_st_val, res_ks_val, st_done, ks_done;

    logic [7:0]           st_plain [NST];
    logic [7:0]           ks_plain [NKS];
    logic [7:0]           sbox_t   [256];
    logic [BW-1:0]        sb_pipe  [SBOX_LAT];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rv_mode = 0;

    typedef struct { int due; bit ks; int idx; logic [7:0] val; bit done; } exp_t;
    typedef struct { int cyc; bit ks; logic [7:0] val; logic [3:0] idx; bit done; } obs_t;
    exp_t expq[$];
    obs_t obs[$];
    int   owner = 0;
    int   mcnt = 0;
    int   last_iss[3] = '{-100, -100, -100};
    int   n_grant[3] = '{0, 0, 0};
    int   n_done[3]  = '{0, 0, 0};
    int   ag_done[2] = '{0, 0};

    always #5 clk = ~clk;

    aes_sbox_sched #(
        .SHARES(SHARES), .SBOX_LAT(SBOX_LAT), .NST(NST), .NKS(NKS)
    ) dut (
        .ClkxCI(clk), .RstxBI(rst_n),
        .StReqxSI(st_req), .StDataxDI(st_data),
        .KsReqxSI(ks_req), .KsDataxDI(ks_data),
        .RandValidxSI(rand_valid), .RandReadyxSO(rand_ready),
        .SboxInxDO(sbox_in), .SboxOutxDI(sbox_out),
        .ResxDO(res), .ResIdxxDO(res_idx),
        .ResStValxSO(res_st_val), .ResKsValxSO(res_ks_val),
        .StDonexSO(st_done), .KsDonexSO(ks_done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse then the affine map
    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (a != 8'h00 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] unmask(input logic [BW-1:0] v);
        logic [7:0] a = 8'h00;
        for (int s = 0; s < SHARES; s++) a ^= v[8*s +: 8];
        return a;
    endfunction

    function automatic logic [BW-1:0] share(input logic [7:0] x);
        logic [BW-1:0] v = '0;
        logic [7:0] acc = x;
        for (int s = 1; s < SHARES; s++) begin
            v[8*s +: 8] = 8'($urandom);
            acc ^= v[8*s +: 8];
        end
        v[7:0] = acc;
        return v;
    endfunction

    always @(posedge clk) begin
        sb_pipe[0] <= share(sbox_t[unmask(sbox_in)]);
        for (int i = 1; i < SBOX_LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
    assign sbox_out = sb_pipe[SBOX_LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic load_st(input bit rnd, input int base);
        for (int i = 0; i < NST; i++) begin
            st_plain[i] = rnd ? 8'($urandom) : 8'(base + i);
            st_data[BW*i +: BW] = share(st_plain[i]);
        end
    endtask

    task automatic load_ks(input bit rnd);
        logic [7:0] kw [NKS];
        kw = '{8'h53, 8'h00, 8'h01, 8'hFF};
        for (int i = 0; i < NKS; i++) begin
            ks_plain[i] = rnd ? 8'($urandom) : kw[i];
            ks_data[BW*i +: BW] = share(ks_plain[i]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input bit ks, input int lim, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ks ? ks_done : st_done) && n < lim);
        chk(nm, ks ? ks_done : st_done, 1);
    endtask

    task automatic agent(input bit ks, input int nb);
        int g;
        for (int b = 0; b < nb; b++) begin
            g = $urandom_range(0, 5);
            step(g);
            if (ks) begin load_ks(1); ks_req = 1'b1; end
            else    begin load_st(1, 0); st_req = 1'b1; end
            wait_done(ks, 400, ks ? "soak_ks_done" : "soak_st_done");
            if (ks) ks_req = 1'b0; else st_req = 1'b0;
            ag_done[ks]++;
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rv_mode)
            0:       rand_valid = 1'b1;
            1:       rand_valid = ~rand_valid;
            default: rand_valid = ($urandom_range(0, 3) != 0);
        endcase
    end

    // reference scheduler: owner, byte count and per-requester last-issue cycle
    initial begin
        exp_t       e;
        bit         iss;
        logic [7:0] want;
        int         nb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
                owner = 0;
                mcnt = 0;
                last_iss = '{-100, -100, -100};
                chk("reset_outputs", {res_st_val, res_ks_val, st_done, ks_done, rand_ready,
                                      res_idx, res, sbox_in}, 64'd0);
            end else begin
                iss = (owner != 0) && rand_valid;
                chk("rand_ready", rand_ready, iss);
                if (iss) begin
                    want = (owner == 1) ? ks_plain[mcnt] : st_plain[mcnt];
                    nb = (owner == 1) ? NKS : NST;
                    chk("sbox_in", unmask(sbox_in), want);
                    expq.push_back('{cyc + LAT, owner == 1, mcnt, sbox_t[want], mcnt == nb - 1});
                end else begin
                    chk("sbox_in_idle", sbox_in, 0);
                end
                if (res_st_val || res_ks_val)
                    obs.push_back('{cyc, res_ks_val, unmask(res), res_idx, st_done || ks_done});
                if (expq.size() > 0 && expq[0].due == cyc) begin
                    e = expq.pop_front();
                    chk("res_st_val", res_st_val, !e.ks);
                    chk("res_ks_val", res_ks_val, e.ks);
                    chk("res_value", unmask(res), e.val);
                    chk("res_idx", res_idx, e.idx);
                    chk("st_done", st_done, e.done && !e.ks);
                    chk("ks_done", ks_done, e.done && e.ks);
                    if (e.done) n_done[e.ks ? 1 : 2]++;
                end else begin
                    chk("no_result", {res_st_val, res_ks_val, st_done, ks_done}, 0);
                end
                if (iss) begin
                    mcnt++;
                    if (mcnt == nb) begin
                        last_iss[owner] = cyc;
                        owner = 0;
                        mcnt = 0;
                    end
                end
                if (owner == 0) begin
                    if (ks_req && cyc > last_iss[1] + LAT)      owner = 1;
                    else if (st_req && cyc > last_iss[2] + LAT) owner = 2;
                    if (owner != 0) n_grant[owner]++;
                end
            end
            cyc++;
        end
    end

    initial begin
        #800000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int c0, n, g0k, g0s, d0k, d0s;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_ref(8'(i));
        chk("sbox_00", sbox_t[8'h00], 8'h63);
        chk("sbox_01", sbox_t[8'h01], 8'h7C);
        chk("sbox_02", sbox_t[8'h02], 8'h77);
        chk("sbox_0f", sbox_t[8'h0F], 8'h76);
        chk("sbox_53", sbox_t[8'h53], 8'hED);
        chk("sbox_ff", sbox_t[8'hFF], 8'h16);
        load_st(0, 0);
        load_ks(0);

        step(3);
        rst_n = 1'b1;
        step(2);

        // 1: plain state batch 0x00..0x0F
        obs.delete();
        load_st(0, 0);
        st_req = 1'b1;
        c0 = cyc;
        wait_done(0, 100, "t1_done");
        st_req = 1'b0;
        step(2);
        chk("t1_count", obs.size(), 16);
        if (obs.size() >= 16) begin
            chk("t1_res0", obs[0].val, 8'h63);
            chk("t1_res1", obs[1].val, 8'h7C);
            chk("t1_res2", obs[2].val, 8'h77);
            chk("t1_res15", obs[15].val, 8'h76);
            chk("t1_idx15", obs[15].idx, 15);
            chk("t1_done_flag", obs[15].done, 1);
            chk("t1_done_latency", obs[15].cyc - c0, 1 + (NST - 1) + LAT);
        end

        // 2: simultaneous requests, key word first
        obs.delete();
        load_ks(0);
        load_st(1, 0);
        st_req = 1'b1;
        ks_req = 1'b1;
        wait_done(1, 100, "t2_ks_done");
        ks_req = 1'b0;
        wait_done(0, 100, "t2_st_done");
        st_req = 1'b0;
        step(2);
        chk("t2_count", obs.size(), 20);
        if (obs.size() >= 20) begin
            chk("t2_ks0", {obs[0].ks, obs[0].val}, 9'h1ED);
            chk("t2_ks1", {obs[1].ks, obs[1].val}, 9'h163);
            chk("t2_ks2", {obs[2].ks, obs[2].val}, 9'h17C);
            chk("t2_ks3", {obs[3].ks, obs[3].val}, 9'h116);
            chk("t2_st_first", {obs[4].ks, obs[4].idx}, 5'h00);
            chk("t2_no_gap", obs[19].cyc - obs[0].cyc, 19);
        end

        // 3: randomness available every other cycle
        rv_mode = 1;
        obs.delete();
        load_st(1, 0);
        st_req = 1'b1;
        wait_done(0, 100, "t3_done");
        st_req = 1'b0;
        rv_mode = 0;
        step(2);
        chk("t3_count", obs.size(), 16);
        if (obs.size() >= 16) chk("t3_spacing", obs[15].cyc - obs[0].cyc, 30);

        // 4: reset in the middle of a state batch
        load_st(1, 0);
        st_req = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 7; i++) begin
            @(posedge clk); #1;
            if (rand_ready) n++;
        end
        chk("t4_seven_issues", n, 7);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("t4_outputs_cleared", {res_st_val, res_ks_val, st_done, ks_done, rand_ready,
                                   res_idx, res, sbox_in}, 64'd0);
        obs.delete();
        st_req = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(12);
        chk("t4_no_stale_results", obs.size(), 0);
        load_st(1, 0);
        st_req = 1'b1;
        wait_done(0, 100, "t4_new_done");
        st_req = 1'b0;
        step(2);
        chk("t4_new_count", obs.size(), 16);

        // 5: key schedule held requesting, state batch fills the gap
        obs.delete();
        load_ks(1);
        load_st(1, 0);
        ks_req = 1'b1;
        st_req = 1'b1;
        wait_done(1, 100, "t5_ks1_done");
        wait_done(0, 100, "t5_st_done");
        st_req = 1'b0;
        wait_done(1, 100, "t5_ks2_done");
        ks_req = 1'b0;
        step(2);
        chk("t5_count", obs.size(), 24);
        if (obs.size() >= 24) begin
            chk("t5_ks_last", {obs[3].ks, obs[3].idx}, 5'h13);
            chk("t5_st_first", {obs[4].ks, obs[4].idx}, 5'h00);
            chk("t5_st_last", {obs[19].ks, obs[19].idx}, 5'h0F);
            chk("t5_ks_again", {obs[20].ks, obs[20].idx}, 5'h10);
            chk("t5_no_gap", obs[23].cyc - obs[0].cyc, 23);
        end

        // 6: random soak
        g0k = n_grant[1]; g0s = n_grant[2];
        d0k = n_done[1];  d0s = n_done[2];
        rv_mode = 2;
        fork
            agent(1, NB_SOAK);
            agent(0, NB_SOAK);
        join
        rv_mode = 0;
        step(10);
        chk("soak_ks_agent", ag_done[1], NB_SOAK);
        chk("soak_st_agent", ag_done[0], NB_SOAK);
        chk("soak_ks_grants_vs_dones", n_done[1] - d0k, n_grant[1] - g0k);
        chk("soak_st_grants_vs_dones", n_done[2] - d0s, n_grant[2] - g0s);
        chk("soak_pending_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
